// File: rtl/sipo_frame_ctrl_pkg.sv
// Shared types and helpers for the serial-in/parallel-out frame controller.
//   sipo_state_t    : controller FSM state encoding (IDLE, SHIFT)
//   bit_cnt_width() : width of the per-frame bit counter for a given word width
package sipo_frame_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } sipo_state_t;

  localparam int SIPO_WIDTH_DEF = 8;
  localparam int SIPO_BC_W_DEF  = $clog2(SIPO_WIDTH_DEF + 1);

  // Counter must represent 0..width inclusive.
  function automatic int bit_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_frame_ctrl_shift_reg_sipo_en.sv
// Enabled MSB-first serial-in/parallel-out shift register.
//   clk      : clock, updates on posedge
//   reset    : asynchronous, active-low; clears dataout
//   shift_en : shift datain in at the LSB this cycle
//   restart  : with shift_en, discard contents and load datain as the only bit
//   datain   : serial bit
//   dataout  : parallel contents, oldest bit at the MSB
module shift_reg_sipo_en #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             restart,
  input  logic             datain,
  output logic [WIDTH-1:0] dataout
);

  if (WIDTH == 1) begin : g_one
    // A restart and a plain shift are indistinguishable for a single bit.
    logic unused_restart;
    assign unused_restart = restart;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        dataout <= '0;
      end else if (shift_en) begin
        dataout <= datain;
      end
    end
  end else begin : g_multi
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        dataout <= '0;
      end else if (shift_en) begin
        if (restart) begin
          dataout <= WIDTH'(datain);
        end else begin
          dataout <= {dataout[WIDTH-2:0], datain};
        end
      end
    end
  end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Receive-side frame controller: detects start of frame, counts qualified
// serial bits, assembles WIDTH-bit words MSB first and hands them to a
// one-entry output buffer with a valid/ready handshake.
//   clk, reset (async active-low)
//   sdin, sdin_valid, sof       : serial front end
//   word, word_valid, word_ready: parallel consumer handshake
//   busy                        : frame in progress
//   overrun, aborted, clr_flags : sticky error flags and their clear
//   frame_cnt                   : delivered-word count, wraps
//
// state | meaning
// IDLE  | waiting for sof with sdin_valid
// SHIFT | frame in progress, bit_cnt bits accepted so far
module sipo_frame_ctrl
  import sipo_frame_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sdin,
  input  logic             sdin_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy,
  output logic             overrun,
  output logic             aborted,
  input  logic             clr_flags,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int BC_W = bit_cnt_width(WIDTH);

  sipo_state_t      state;
  logic [BC_W-1:0]  bit_cnt;
  logic [WIDTH-2:0] shreg;
  logic [WIDTH-1:0] new_word;
  logic             start, abort, last_bit, shift_en, restart, drain;

  always_comb begin
    start    = (state == IDLE) & sdin_valid & sof;
    abort    = (state == SHIFT) & sdin_valid & sof;
    last_bit = (state == SHIFT) & sdin_valid & ~sof & (bit_cnt == BC_W'(WIDTH - 1));
    // The last bit bypasses the shift register and lands straight in the word,
    // so the register is never shifted on that edge.
    shift_en = start | ((state == SHIFT) & sdin_valid & ~last_bit);
    restart  = sdin_valid & sof;
    drain    = word_valid & word_ready;
    new_word = {shreg, sdin};
  end

  // Only WIDTH-1 bits need storage; the final bit is taken from sdin.
  shift_reg_sipo_en #(
    .WIDTH(WIDTH - 1)
  ) u_sipo (
    .clk     (clk),
    .reset   (reset),
    .shift_en(shift_en),
    .restart (restart),
    .datain  (sdin),
    .dataout (shreg)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bit_cnt <= BC_W'(1);
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (sdin_valid) begin
            if (sof) begin
              bit_cnt <= BC_W'(1);
            end else if (last_bit) begin
              bit_cnt <= '0;
              state   <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + BC_W'(1);
            end
          end
        end
        default: begin
          state   <= IDLE;
          bit_cnt <= '0;
        end
      endcase
    end
  end

  assign busy = (state == SHIFT);

  // Output buffer: a completion is accepted when the buffer is empty or being
  // drained on this same edge; otherwise the old word is kept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word       <= '0;
      word_valid <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      if (drain) begin
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
      if (last_bit && (!word_valid || word_ready)) begin
        word       <= new_word;
        word_valid <= 1'b1;
      end else if (drain) begin
        word_valid <= 1'b0;
      end
    end
  end

  // Sticky flags; a set event beats a clear in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun <= 1'b0;
      aborted <= 1'b0;
    end else begin
      if (last_bit && word_valid && !word_ready) begin
        overrun <= 1'b1;
      end else if (clr_flags) begin
        overrun <= 1'b0;
      end
      if (abort) begin
        aborted <= 1'b1;
      end else if (clr_flags) begin
        aborted <= 1'b0;
      end
    end
  end

endmodule
